rrf_free_list: RTL and testbench

- Rename-register (RRF) tag allocator that feeds the dispatch unit. It supplies up to two free RRF tags per cycle to the two dispatch slots and reclaims up to two tags per cycle from ROB commit.
- Internally a circular free-tag FIFO with head/tail pointers and an occupancy count. It also produces the 32-bit busy vector that dispatch and ROB use.
- Tag 0 is reserved as "no tag" and is never allocated.

---
 rtl/rrf_free_list.sv | 101 ++++++++++
 tb/tb_rrf_free_list.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rrf_free_list.sv
// rrf_free_list: dual-port rename-register tag allocator built on a circular free-tag FIFO.
// Optional macro RRF_FREE_CHECK_EN adds illegal-free detection and the sticky free_err output.
module rrf_free_list #(
    parameter int NUM_TAGS = 32,
    parameter int TAG_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                alloc_req_1,
    input  logic                alloc_req_2,
    output logic                alloc_gnt_1,
    output logic                alloc_gnt_2,
    output logic [TAG_W-1:0]    alloc_tag_1,
    output logic [TAG_W-1:0]    alloc_tag_2,
    input  logic                free_valid_1,
    input  logic [TAG_W-1:0]    free_tag_1,
    input  logic                free_valid_2,
    input  logic [TAG_W-1:0]    free_tag_2,
    output logic [TAG_W-1:0]    free_count,
`ifdef RRF_FREE_CHECK_EN
    output logic                free_err,
`endif
    output logic                has_one,
    output logic                has_two,
    output logic [NUM_TAGS-1:0] rrf_busy_status
);
    localparam int DEPTH = NUM_TAGS - 1;

    logic [TAG_W-1:0]    fifo [DEPTH];
    logic [TAG_W-1:0]    head, tail, count;
    logic [NUM_TAGS-1:0] busy;
    logic [TAG_W-1:0]    head_1, head_nxt, tail_1, tail_nxt, count_nxt;
    logic [NUM_TAGS-1:0] busy_nxt;
    logic                full, ok_1, ok_2;
    logic [1:0]          n_gnt, n_free;

    // Pointers live in 0..DEPTH-1; tail is the next write slot, so full means tail==head.
    function automatic logic [TAG_W-1:0] inc(input logic [TAG_W-1:0] p);
        return (p == TAG_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Grants, tags and accepted frees are all derived from registered state only.
    always_comb begin
        has_one     = count != '0;
        has_two     = count >= TAG_W'(2);
        full        = count == TAG_W'(DEPTH);
        alloc_gnt_1 = alloc_req_1 & has_one & ~flush;
        alloc_gnt_2 = alloc_req_2 & ~flush & (alloc_req_1 ? has_two : has_one);
        head_1      = inc(head);
        alloc_tag_1 = fifo[head];
        alloc_tag_2 = alloc_req_1 ? fifo[head_1] : fifo[head];
        ok_1        = free_valid_1 & (free_tag_1 != '0) & ~full & ~flush;
        ok_2        = free_valid_2 & (free_tag_2 != '0) & ~flush
                      & (({1'b0, count} + {{TAG_W{1'b0}}, ok_1}) < (TAG_W + 1)'(DEPTH));
`ifdef RRF_FREE_CHECK_EN
        ok_1        = ok_1 & busy[free_tag_1];
        ok_2        = ok_2 & busy[free_tag_2] & ~(free_valid_1 & (free_tag_1 == free_tag_2));
`endif
        n_gnt       = {1'b0, alloc_gnt_1} + {1'b0, alloc_gnt_2};
        n_free      = {1'b0, ok_1} + {1'b0, ok_2};
        head_nxt    = (n_gnt == 2'd2) ? inc(head_1) : (n_gnt == 2'd1) ? head_1 : head;
        tail_1      = inc(tail);
        tail_nxt    = (n_free == 2'd2) ? inc(tail_1) : (n_free == 2'd1) ? tail_1 : tail;
        count_nxt   = count - TAG_W'(n_gnt) + TAG_W'(n_free);
        busy_nxt    = busy;
        busy_nxt    = alloc_gnt_1 ? (busy_nxt | (NUM_TAGS'(1) << alloc_tag_1)) : busy_nxt;
        busy_nxt    = alloc_gnt_2 ? (busy_nxt | (NUM_TAGS'(1) << alloc_tag_2)) : busy_nxt;
        busy_nxt    = ok_1 ? (busy_nxt & ~(NUM_TAGS'(1) << free_tag_1)) : busy_nxt;
        busy_nxt    = ok_2 ? (busy_nxt & ~(NUM_TAGS'(1) << free_tag_2)) : busy_nxt;
    end

    assign free_count      = count;
    assign rrf_busy_status = busy;

    // State update: reset and flush both reload the FIFO with tags 1..DEPTH in order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            for (int i = 0; i < DEPTH; i++) fifo[i] <= TAG_W'(i + 1);
            head  <= '0;
            tail  <= '0;
            count <= TAG_W'(DEPTH);
            busy  <= NUM_TAGS'(1);
        end else begin
            if (ok_1) fifo[tail] <= free_tag_1;
            if (ok_2) fifo[ok_1 ? tail_1 : tail] <= free_tag_2;
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
            busy  <= busy_nxt;
        end
    end

`ifdef RRF_FREE_CHECK_EN
    // Sticky illegal-free flag; survives flush and clears only on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) free_err <= 1'b0;
        else if (!flush && ((free_valid_1 && !ok_1) || (free_valid_2 && !ok_2))) free_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_rrf_free_list.sv
// tb_rrf_free_list: directed self-checking bench for rrf_free_list.
module tb_rrf_free_list;
    logic        clk = 1'b0;
    logic        rst, flush, alloc_req_1, alloc_req_2;
    logic        alloc_gnt_1, alloc_gnt_2;
    logic [4:0]  alloc_tag_1, alloc_tag_2;
    logic        free_valid_1, free_valid_2;
    logic [4:0]  free_tag_1, free_tag_2, free_count;
    logic        has_one, has_two;
    logic [31:0] rrf_busy_status;
`ifdef RRF_FREE_CHECK_EN
    logic        free_err;
`endif
    int errors = 0;
    int checks = 0;

    rrf_free_list dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_req_1(alloc_req_1), .alloc_req_2(alloc_req_2),
        .alloc_gnt_1(alloc_gnt_1), .alloc_gnt_2(alloc_gnt_2),
        .alloc_tag_1(alloc_tag_1), .alloc_tag_2(alloc_tag_2),
        .free_valid_1(free_valid_1), .free_tag_1(free_tag_1),
        .free_valid_2(free_valid_2), .free_tag_2(free_tag_2),
        .free_count(free_count),
`ifdef RRF_FREE_CHECK_EN
        .free_err(free_err),
`endif
        .has_one(has_one), .has_two(has_two),
        .rrf_busy_status(rrf_busy_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic idle();
        flush = 0; alloc_req_1 = 0; alloc_req_2 = 0;
        free_valid_1 = 0; free_valid_2 = 0; free_tag_1 = 0; free_tag_2 = 0;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #7 rst = 1'b1;
        #1;
        chk("rst_count", 32'(free_count), 31);
        chk("rst_busy", rrf_busy_status, 32'h1);
        chk("rst_tag1", 32'(alloc_tag_1), 1);
        chk("rst_has_one", 32'(has_one), 1);
        chk("rst_has_two", 32'(has_two), 1);
        chk("rst_no_gnt", 32'({alloc_gnt_1, alloc_gnt_2}), 0);
        alloc_req_1 = 1;
        #1;
        chk("rst_tag2_pair", 32'(alloc_tag_2), 2);
        alloc_req_1 = 0;
        // both slots for three cycles: (1,2),(3,4),(5,6)
        alloc_req_1 = 1; alloc_req_2 = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("pair_gnt", 32'({alloc_gnt_1, alloc_gnt_2}), 32'b11);
            chk("pair_tag1", 32'(alloc_tag_1), 32'(2 * k + 1));
            chk("pair_tag2", 32'(alloc_tag_2), 32'(2 * k + 2));
            cyc();
        end
        idle();
        #1;
        chk("pair_count", 32'(free_count), 25);
        chk("pair_busy", rrf_busy_status, 32'h7F);
        alloc_req_2 = 1;
        #1;
        chk("slot2_only_gnt", 32'({alloc_gnt_1, alloc_gnt_2}), 32'b01);
        chk("slot2_only_tag", 32'(alloc_tag_2), 7);
        idle();
        free_valid_1 = 1; free_tag_1 = 3; free_valid_2 = 1; free_tag_2 = 5;
        cyc();
        idle();
        #1;
        chk("free2_count", 32'(free_count), 27);
        chk("free2_busy", rrf_busy_status, 32'h57);
        // frees at full and of tag 0 are dropped
        do_reset();
        free_valid_1 = 1; free_tag_1 = 0; free_valid_2 = 1; free_tag_2 = 5;
        cyc();
        idle();
        #1;
        chk("full_drop_count", 32'(free_count), 31);
        chk("full_drop_busy", rrf_busy_status, 32'h1);
`ifdef RRF_FREE_CHECK_EN
        chk("full_drop_err", 32'(free_err), 1);
`endif
        // drain to count=1 then to empty
        do_reset();
        alloc_req_1 = 1; alloc_req_2 = 1;
        for (int k = 0; k < 15; k++) begin
            #1;
            chk("drain_tag1", 32'(alloc_tag_1), 32'(2 * k + 1));
            chk("drain_tag2", 32'(alloc_tag_2), 32'(2 * k + 2));
            cyc();
        end
        #1;
        chk("one_count", 32'(free_count), 1);
        chk("one_has_two", 32'(has_two), 0);
        chk("one_gnt", 32'({alloc_gnt_1, alloc_gnt_2}), 32'b10);
        chk("one_tag1", 32'(alloc_tag_1), 31);
        cyc();
        #1;
        chk("empty_count", 32'(free_count), 0);
        chk("empty_has_one", 32'(has_one), 0);
        chk("empty_gnt", 32'({alloc_gnt_1, alloc_gnt_2}), 0);
        chk("empty_busy", rrf_busy_status, 32'hFFFF_FFFF);
        free_valid_1 = 1; free_tag_1 = 4; free_valid_2 = 1; free_tag_2 = 9;
        #1;
        chk("no_bypass_gnt", 32'({alloc_gnt_1, alloc_gnt_2}), 0);
        cyc();
        free_valid_1 = 0; free_valid_2 = 0;
        #1;
        chk("wrap_count", 32'(free_count), 2);
        chk("wrap_busy", rrf_busy_status, 32'hFFFF_FDEF);
        chk("wrap_gnt", 32'({alloc_gnt_1, alloc_gnt_2}), 32'b11);
        chk("wrap_tag1", 32'(alloc_tag_1), 4);
        chk("wrap_tag2", 32'(alloc_tag_2), 9);
        cyc();
        idle();
        #1;
        chk("wrap_after_count", 32'(free_count), 0);
        chk("wrap_after_busy", rrf_busy_status, 32'hFFFF_FFFF);
        // flush after ten allocations
        do_reset();
        alloc_req_1 = 1; alloc_req_2 = 1;
        repeat (5) cyc();
        #1;
        chk("pre_flush_count", 32'(free_count), 21);
        chk("pre_flush_busy", rrf_busy_status, 32'h7FF);
        flush = 1; free_valid_1 = 1; free_tag_1 = 3;
        #1;
        chk("flush_gnt", 32'({alloc_gnt_1, alloc_gnt_2}), 0);
        cyc();
        idle();
        #1;
        chk("flush_count", 32'(free_count), 31);
        chk("flush_busy", rrf_busy_status, 32'h1);
        chk("flush_tag1", 32'(alloc_tag_1), 1);
`ifdef RRF_FREE_CHECK_EN
        do_reset();
        chk("chk_rst_err", 32'(free_err), 0);
        alloc_req_1 = 1;
        cyc();
        idle();
        free_valid_1 = 1; free_tag_1 = 7; free_valid_2 = 1; free_tag_2 = 7;
        cyc();
        idle();
        #1;
        chk("dbl_err", 32'(free_err), 1);
        chk("dbl_count", 32'(free_count), 30);
        free_valid_1 = 1; free_tag_1 = 0;
        cyc();
        idle();
        #1;
        chk("zero_count", 32'(free_count), 30);
        free_valid_1 = 1; free_tag_1 = 1;
        cyc();
        idle();
        #1;
        chk("legal_count", 32'(free_count), 31);
        chk("legal_busy", rrf_busy_status, 32'h1);
        flush = 1;
        cyc();
        idle();
        #1;
        chk("err_after_flush", 32'(free_err), 1);
        do_reset();
        chk("err_after_rst", 32'(free_err), 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
